// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master controller.
//   SPI_BITS     - bits per transfer
//   DEF_CLK_DIV  - default system clocks per SCLK half-period
//   DEF_CS_LEAD  - default clocks of CS_N low before the first SCLK rise
//   spi_state_t  - controller state encoding (3-bit)
package spi_pkg;

  localparam int unsigned SPI_BITS    = 8;
  localparam int unsigned DEF_CLK_DIV = 4;
  localparam int unsigned DEF_CS_LEAD = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_LEAD = 3'd2,
    ST_XFER = 3'd3,
    ST_DONE = 3'd4
  } spi_state_t;

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider.
//   clk, clr_n - system clock, async active-low reset
//   en         - run the divider; when low the divider is held at the start
//                of a low phase (div_cnt = 0, half = 0)
//   sclk       - SCLK level (the half-phase flop itself)
//   rise/fall  - high in the last cycle of a low/high phase, i.e. on the
//                clock edge where SCLK is about to toggle
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic clr_n,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  logic [7:0] div_cnt;
  logic       half;
  logic       tc;

  assign tc   = en && (div_cnt == 8'(CLK_DIV - 1));
  assign rise = tc && !half;
  assign fall = tc && half;
  assign sclk = half;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      div_cnt <= '0;
      half    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      half    <= 1'b0;
    end else if (tc) begin
      div_cnt <= '0;
      half    <= ~half;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Sequencer for one full-duplex 8-bit SPI mode-0 transfer. Drives the
// external shift register (preset, mode select, shift strobe), SCLK and CS_N.
//   clk, clr_n          - system clock, async active-low reset
//   tx_data/valid/ready - host request; accept = tx_valid & tx_ready
//   rx_data/rx_valid    - received byte and its one-cycle update pulse
//   busy                - high outside IDLE
//   sclk, cs_n          - SPI pins
//   sr_p_data           - parallel preset for the shift register
//   sr_sh_ld            - 0 = preset, 1 = shift mode
//   sr_shift            - shift strobe
//   sr_q                - shift-register parallel output
//
// state | meaning
// IDLE  | ready for a request, CS_N high
// LOAD  | preset shift register from sr_p_data, CS_N goes low
// LEAD  | CS_LEAD cycles of CS_N low before the first SCLK edge
// XFER  | 8 SCLK periods, one shift per rising edge
// DONE  | capture sr_q into rx_data, pulse rx_valid
//
// Every output is a flop loaded from the next-state decode, so pins change
// on the same edge as the state they belong to and never glitch.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV,
  parameter int unsigned CS_LEAD = DEF_CS_LEAD
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       sclk,
  output logic       cs_n,
  output logic [7:0] sr_p_data,
  output logic       sr_sh_ld,
  output logic       sr_shift,
  input  logic [7:0] sr_q
);

  spi_state_t state_q;
  spi_state_t state_d;
  logic [3:0] bit_cnt;
  logic [3:0] lead_cnt;
  logic       div_en;
  logic       div_rise;
  logic       div_fall;
  logic       accept;
  logic       lead_end;
  logic       xfer_end;

  assign accept   = tx_valid & tx_ready;
  assign div_en   = (state_q == ST_XFER);
  assign lead_end = (lead_cnt == 4'(CS_LEAD - 1));
  // bit_cnt already reads 8 during the last high phase, so the falling
  // edge that closes it ends the transfer with SCLK back low.
  assign xfer_end = div_fall && (bit_cnt == 4'(SPI_BITS));

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (div_en),
    .sclk  (sclk),
    .rise  (div_rise),
    .fall  (div_fall)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_LEAD;
      ST_LEAD: if (lead_end) state_d = ST_XFER;
      ST_XFER: if (xfer_end) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= ST_IDLE;
      lead_cnt  <= '0;
      bit_cnt   <= '0;
      tx_ready  <= 1'b0;
      busy      <= 1'b0;
      cs_n      <= 1'b1;
      sr_sh_ld  <= 1'b1;
      sr_shift  <= 1'b0;
      sr_p_data <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lead_cnt <= (state_q == ST_LEAD) ? lead_cnt + 4'd1 : 4'd0;
      if (state_q != ST_XFER) begin
        bit_cnt <= '0;
      end else if (div_rise) begin
        bit_cnt <= bit_cnt + 4'd1;
      end
      tx_ready <= (state_d == ST_IDLE);
      busy     <= (state_d != ST_IDLE);
      cs_n     <= (state_d == ST_IDLE);
      sr_sh_ld <= (state_d != ST_LOAD);
      sr_shift <= div_rise;
      rx_valid <= (state_d == ST_DONE);
      if (accept) begin
        sr_p_data <= tx_data;
      end
      if (state_d == ST_DONE) begin
        rx_data <= sr_q;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
`timescale 1ns/1ps
module tb_spi_master_ctrl;

  localparam int CD_A  = 4;
  localparam int LAT_A = 1 + 2 + 16 * 4 + 1;
  localparam int LAT_B = 1 + 1 + 16 * 2 + 1;
  localparam int PER_B = 4;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  logic clk   = 1'b0;
  logic clr_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // DUT A: default parameters
  logic [7:0] tx_data_a;
  logic       tx_valid_a;
  logic       tx_ready_a, rx_valid_a, busy_a, sclk_a, cs_n_a, sr_sh_ld_a, sr_shift_a;
  logic [7:0] rx_data_a, sr_p_data_a;
  logic [7:0] sr_q_a;
  logic       miso_a;
  bit         miso_one = 1'b0;

  spi_master_ctrl u_dut_a (
    .clk       (clk),
    .clr_n     (clr_n),
    .tx_data   (tx_data_a),
    .tx_valid  (tx_valid_a),
    .tx_ready  (tx_ready_a),
    .rx_data   (rx_data_a),
    .rx_valid  (rx_valid_a),
    .busy      (busy_a),
    .sclk      (sclk_a),
    .cs_n      (cs_n_a),
    .sr_p_data (sr_p_data_a),
    .sr_sh_ld  (sr_sh_ld_a),
    .sr_shift  (sr_shift_a),
    .sr_q      (sr_q_a)
  );

  // external shift register model, MISO looped from MOSI unless forced high
  assign miso_a = miso_one ? 1'b1 : sr_q_a[7];
  always @(posedge clk) begin
    if (!sr_sh_ld_a) sr_q_a <= sr_p_data_a;
    else if (sr_shift_a) sr_q_a <= {sr_q_a[6:0], miso_a};
  end

  // DUT B: CLK_DIV=2, CS_LEAD=1
  logic [7:0] tx_data_b;
  logic       tx_valid_b;
  logic       tx_ready_b, rx_valid_b, busy_b, sclk_b, cs_n_b, sr_sh_ld_b, sr_shift_b;
  logic [7:0] rx_data_b, sr_p_data_b;
  logic [7:0] sr_q_b;

  spi_master_ctrl #(.CLK_DIV(2), .CS_LEAD(1)) u_dut_b (
    .clk       (clk),
    .clr_n     (clr_n),
    .tx_data   (tx_data_b),
    .tx_valid  (tx_valid_b),
    .tx_ready  (tx_ready_b),
    .rx_data   (rx_data_b),
    .rx_valid  (rx_valid_b),
    .busy      (busy_b),
    .sclk      (sclk_b),
    .cs_n      (cs_n_b),
    .sr_p_data (sr_p_data_b),
    .sr_sh_ld  (sr_sh_ld_b),
    .sr_shift  (sr_shift_b),
    .sr_q      (sr_q_b)
  );

  always @(posedge clk) begin
    if (!sr_sh_ld_b) sr_q_b <= sr_p_data_b;
    else if (sr_shift_b) sr_q_b <= {sr_q_b[6:0], sr_q_b[7]};
  end

  // monitors (sample on the falling edge)
  int rises_a = 0, shifts_a = 0, ld_low_a = 0, rxv_a = 0, acc_cnt_a = 0;
  int hi_run_a = 0, hi_runs_a = 0, hi_bad_a = 0, cs_run_a = 0, cs_last_a = 0;
  int busy_rdy_bad_a = 0;
  logic prev_sclk_a = 1'b0;
  logic [7:0] rx_dat_log_a [32];
  int         rx_cyc_log_a [32];

  always @(negedge clk) begin
    prev_sclk_a <= sclk_a;
    if (sclk_a === 1'b1 && prev_sclk_a === 1'b0) rises_a <= rises_a + 1;
    if (sr_shift_a === 1'b1) shifts_a <= shifts_a + 1;
    if (sr_sh_ld_a === 1'b0) ld_low_a <= ld_low_a + 1;
    if (tx_valid_a === 1'b1 && tx_ready_a === 1'b1) acc_cnt_a <= acc_cnt_a + 1;
    if (busy_a === 1'b1 && tx_ready_a === 1'b1) busy_rdy_bad_a <= busy_rdy_bad_a + 1;
    if (rx_valid_a === 1'b1) begin
      rx_dat_log_a[rxv_a % 32] <= rx_data_a;
      rx_cyc_log_a[rxv_a % 32] <= cyc;
      rxv_a <= rxv_a + 1;
    end
    if (sclk_a === 1'b1) hi_run_a <= hi_run_a + 1;
    else if (hi_run_a != 0) begin
      hi_runs_a <= hi_runs_a + 1;
      if (hi_run_a != CD_A) hi_bad_a <= hi_bad_a + 1;
      hi_run_a <= 0;
    end
    if (cs_n_a === 1'b1) cs_run_a <= cs_run_a + 1;
    else if (cs_run_a != 0) begin
      cs_last_a <= cs_run_a;
      cs_run_a  <= 0;
    end
  end

  int rises_b = 0, per_cnt_b = 0, per_bad_b = 0, rxv_b = 0, rx_cyc_b = 0, last_rise_b = 0;
  logic [7:0] rx_last_b = 8'h00;
  logic prev_sclk_b = 1'b0;
  bit   have_rise_b = 1'b0;

  always @(negedge clk) begin
    prev_sclk_b <= sclk_b;
    if (cs_n_b === 1'b1) have_rise_b <= 1'b0;
    else if (sclk_b === 1'b1 && prev_sclk_b === 1'b0) begin
      rises_b <= rises_b + 1;
      if (have_rise_b) begin
        per_cnt_b <= per_cnt_b + 1;
        if (cyc - last_rise_b != PER_B) per_bad_b <= per_bad_b + 1;
      end
      last_rise_b <= cyc;
      have_rise_b <= 1'b1;
    end
    if (rx_valid_b === 1'b1) begin
      rx_last_b <= rx_data_b;
      rx_cyc_b  <= cyc;
      rxv_b     <= rxv_b + 1;
    end
  end

  exp_t exp_q_a[$];
  int   rd_a = 0;

  // waits for tx_ready on a falling edge; the accept is the next rising edge
  task automatic wait_ready_a(input int budget, output bit ok, output int acc);
    ok  = 1'b0;
    acc = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (tx_ready_a === 1'b1) begin
        ok  = 1'b1;
        acc = cyc;
      end
    end
  endtask

  task automatic send_a(input logic [7:0] d, output bit ok, output int acc);
    @(posedge clk); #1;
    tx_data_a  = d;
    tx_valid_a = 1'b1;
    wait_ready_a(200, ok, acc);
    @(posedge clk); #1;
    tx_valid_a = 1'b0;
  endtask

  task automatic wait_rx_a(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (rxv_a > rd_a) ok = 1'b1;
    end
  endtask

  task automatic push_a(input logic [7:0] d, input int c);
    exp_t e;
    e.d = d;
    e.c = c;
    exp_q_a.push_back(e);
  endtask

  task automatic test_reset();
    tx_valid_a = 1'b0; tx_data_a = 8'h00;
    tx_valid_b = 1'b0; tx_data_b = 8'h00;
    #1 clr_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (cs_n_a !== 1'b1) begin bad++; $display("FAIL reset_cs_n got=%b want=1", cs_n_a); end
    total++; if (sclk_a !== 1'b0) begin bad++; $display("FAIL reset_sclk got=%b want=0", sclk_a); end
    total++; if (sr_sh_ld_a !== 1'b1) begin bad++; $display("FAIL reset_sh_ld got=%b want=1", sr_sh_ld_a); end
    total++; if (sr_shift_a !== 1'b0) begin bad++; $display("FAIL reset_shift got=%b want=0", sr_shift_a); end
    total++; if (sr_p_data_a !== 8'h00) begin bad++; $display("FAIL reset_p_data got=%h want=00", sr_p_data_a); end
    total++; if (rx_data_a !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h want=00", rx_data_a); end
    total++; if (rx_valid_a !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_a); end
    total++; if (tx_ready_a !== 1'b0) begin bad++; $display("FAIL reset_tx_ready got=%b want=0", tx_ready_a); end
    clr_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (tx_ready_a !== 1'b1) begin bad++; $display("FAIL idle_tx_ready got=%b want=1", tx_ready_a); end
    total++; if (tx_ready_b !== 1'b1) begin bad++; $display("FAIL idle_tx_ready_b got=%b want=1", tx_ready_b); end
  endtask

  task automatic test_single_byte();
    bit ok; int acc, r0, s0, k; exp_t e;
    miso_one = 1'b0;
    r0 = rises_a; s0 = shifts_a;
    send_a(8'hA5, ok, acc);
    total++; if (!ok) begin bad++; $display("FAIL single_accept timed out"); end
    push_a(8'hA5, acc + LAT_A);
    total++; if (sr_p_data_a !== 8'hA5) begin bad++; $display("FAIL single_p_data got=%h want=a5", sr_p_data_a); end
    wait_rx_a(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_rx timed out"); end
    if (ok) begin
      e = exp_q_a.pop_front(); k = rd_a % 32; rd_a++;
      total++; if (rx_dat_log_a[k] !== e.d) begin bad++; $display("FAIL single_rx_data got=%h want=%h", rx_dat_log_a[k], e.d); end
      total++; if (rx_cyc_log_a[k] != e.c) begin bad++; $display("FAIL single_latency got=%0d want=%0d", rx_cyc_log_a[k] - acc, e.c - acc); end
    end
    @(negedge clk);
    total++; if (rises_a - r0 != 8) begin bad++; $display("FAIL single_sclk_rises got=%0d want=8", rises_a - r0); end
    total++; if (shifts_a - s0 != 8) begin bad++; $display("FAIL single_shifts got=%0d want=8", shifts_a - s0); end
  endtask

  task automatic test_const_miso();
    bit ok; int acc, l0, h0, hb0, k; exp_t e;
    miso_one = 1'b1;
    l0 = ld_low_a; h0 = hi_runs_a; hb0 = hi_bad_a;
    send_a(8'h3C, ok, acc);
    total++; if (!ok) begin bad++; $display("FAIL const_accept timed out"); end
    push_a(8'hFF, acc + LAT_A);
    wait_rx_a(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL const_rx timed out"); end
    if (ok) begin
      e = exp_q_a.pop_front(); k = rd_a % 32; rd_a++;
      total++; if (rx_dat_log_a[k] !== e.d) begin bad++; $display("FAIL const_rx_data got=%h want=%h", rx_dat_log_a[k], e.d); end
      total++; if (rx_cyc_log_a[k] != e.c) begin bad++; $display("FAIL const_latency got=%0d want=%0d", rx_cyc_log_a[k] - acc, e.c - acc); end
    end
    @(negedge clk);
    total++; if (ld_low_a - l0 != 1) begin bad++; $display("FAIL const_load_cycles got=%0d want=1", ld_low_a - l0); end
    total++; if (hi_runs_a - h0 != 8) begin bad++; $display("FAIL const_high_phases got=%0d want=8", hi_runs_a - h0); end
    total++; if (hi_bad_a - hb0 != 0) begin bad++; $display("FAIL const_high_time bad_phases=%0d want=0", hi_bad_a - hb0); end
    miso_one = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok; int acc1, acc2, bb0, k1, k2; exp_t e;
    bb0 = busy_rdy_bad_a;
    @(posedge clk); #1;
    tx_data_a  = 8'h01;
    tx_valid_a = 1'b1;
    wait_ready_a(200, ok, acc1);
    total++; if (!ok) begin bad++; $display("FAIL b2b_accept1 timed out"); end
    push_a(8'h01, acc1 + LAT_A);
    @(posedge clk); #1;
    tx_data_a = 8'h80;
    wait_ready_a(200, ok, acc2);
    total++; if (!ok) begin bad++; $display("FAIL b2b_accept2 timed out"); end
    push_a(8'h80, acc2 + LAT_A);
    @(posedge clk); #1;
    tx_valid_a = 1'b0;
    total++; if (acc2 - acc1 != LAT_A + 1) begin bad++; $display("FAIL b2b_accept_gap got=%0d want=%0d", acc2 - acc1, LAT_A + 1); end
    repeat (3) @(negedge clk);
    total++; if (cs_last_a != 1) begin bad++; $display("FAIL b2b_cs_high got=%0d want=1", cs_last_a); end
    k1 = rd_a % 32;
    wait_rx_a(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_rx1 timed out"); end
    if (ok) begin
      e = exp_q_a.pop_front(); rd_a++;
      total++; if (rx_dat_log_a[k1] !== e.d) begin bad++; $display("FAIL b2b_rx1_data got=%h want=%h", rx_dat_log_a[k1], e.d); end
      total++; if (rx_cyc_log_a[k1] != e.c) begin bad++; $display("FAIL b2b_rx1_cycle got=%0d want=%0d", rx_cyc_log_a[k1], e.c); end
    end
    k2 = rd_a % 32;
    wait_rx_a(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_rx2 timed out"); end
    if (ok) begin
      e = exp_q_a.pop_front(); rd_a++;
      total++; if (rx_dat_log_a[k2] !== e.d) begin bad++; $display("FAIL b2b_rx2_data got=%h want=%h", rx_dat_log_a[k2], e.d); end
      total++; if (rx_cyc_log_a[k2] - rx_cyc_log_a[k1] != LAT_A + 1) begin
        bad++; $display("FAIL b2b_rx_gap got=%0d want=%0d", rx_cyc_log_a[k2] - rx_cyc_log_a[k1], LAT_A + 1);
      end
    end
    @(negedge clk);
    total++; if (busy_rdy_bad_a != bb0) begin bad++; $display("FAIL b2b_ready_while_busy cycles=%0d want=0", busy_rdy_bad_a - bb0); end
  endtask

  task automatic test_fast_div();
    bit ok; int acc, r0, pc0, pb0, x0;
    ok = 1'b0; acc = 0;
    r0 = rises_b; pc0 = per_cnt_b; pb0 = per_bad_b; x0 = rxv_b;
    @(posedge clk); #1;
    tx_data_b  = 8'hFF;
    tx_valid_b = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (tx_ready_b === 1'b1) begin ok = 1'b1; acc = cyc; end
    end
    @(posedge clk); #1;
    tx_valid_b = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL fast_accept timed out"); end
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (rxv_b > x0) ok = 1'b1;
    end
    total++; if (!ok) begin bad++; $display("FAIL fast_rx timed out"); end
    if (ok) begin
      total++; if (rx_last_b !== 8'hFF) begin bad++; $display("FAIL fast_rx_data got=%h want=ff", rx_last_b); end
      total++; if (rx_cyc_b - acc != LAT_B) begin bad++; $display("FAIL fast_latency got=%0d want=%0d", rx_cyc_b - acc, LAT_B); end
    end
    total++; if (rises_b - r0 != 8) begin bad++; $display("FAIL fast_sclk_rises got=%0d want=8", rises_b - r0); end
    total++; if (per_cnt_b - pc0 != 7 || per_bad_b != pb0) begin
      bad++; $display("FAIL fast_sclk_period periods=%0d off_period=%0d want 7 and 0", per_cnt_b - pc0, per_bad_b - pb0);
    end
  endtask

  task automatic test_busy_request();
    bit ok; int acc, a0, k; exp_t e;
    send_a(8'h12, ok, acc);
    total++; if (!ok) begin bad++; $display("FAIL busyreq_accept timed out"); end
    push_a(8'h12, acc + LAT_A);
    repeat (20) @(negedge clk);
    a0 = acc_cnt_a;
    @(posedge clk); #1;
    tx_data_a  = 8'h55;
    tx_valid_a = 1'b1;
    repeat (3) @(posedge clk);
    #1 tx_valid_a = 1'b0;
    @(negedge clk);
    total++; if (sr_p_data_a !== 8'h12) begin bad++; $display("FAIL busyreq_p_data got=%h want=12", sr_p_data_a); end
    wait_rx_a(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL busyreq_rx timed out"); end
    if (ok) begin
      e = exp_q_a.pop_front(); k = rd_a % 32; rd_a++;
      total++; if (rx_dat_log_a[k] !== e.d) begin bad++; $display("FAIL busyreq_rx_data got=%h want=%h", rx_dat_log_a[k], e.d); end
    end
    repeat (80) @(negedge clk);
    total++; if (acc_cnt_a != a0) begin bad++; $display("FAIL busyreq_accepts got=%0d want=0", acc_cnt_a - a0); end
    total++; if (rxv_a != rd_a) begin bad++; $display("FAIL busyreq_extra_rx got=%0d want=0", rxv_a - rd_a); end
    total++; if (sr_p_data_a !== 8'h12) begin bad++; $display("FAIL busyreq_p_data_end got=%h want=12", sr_p_data_a); end
  endtask

  task automatic test_reset_mid();
    bit ok; int acc, s0, n, x0, k; exp_t e;
    send_a(8'h5A, ok, acc);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_accept timed out"); end
    s0 = shifts_a; n = 0;
    while (shifts_a - s0 < 3 && n < 300) begin @(negedge clk); n++; end
    total++; if (shifts_a - s0 < 3) begin bad++; $display("FAIL rstmid_reach_bit3 shifts=%0d want=3", shifts_a - s0); end
    #2 clr_n = 1'b0;
    #1;
    total++; if (cs_n_a !== 1'b1) begin bad++; $display("FAIL rstmid_cs_n got=%b want=1", cs_n_a); end
    total++; if (sclk_a !== 1'b0) begin bad++; $display("FAIL rstmid_sclk got=%b want=0", sclk_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy_a); end
    total++; if (sr_sh_ld_a !== 1'b1 || sr_shift_a !== 1'b0) begin
      bad++; $display("FAIL rstmid_sr_ctl got=%b%b want=10", sr_sh_ld_a, sr_shift_a);
    end
    x0 = rxv_a;
    @(negedge clk);
    clr_n = 1'b1;
    repeat (100) @(negedge clk);
    total++; if (rxv_a != x0) begin bad++; $display("FAIL rstmid_rx_after_reset got=%0d want=0", rxv_a - x0); end
    send_a(8'hC3, ok, acc);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_next_accept timed out"); end
    push_a(8'hC3, acc + LAT_A);
    wait_rx_a(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_next_rx timed out"); end
    if (ok) begin
      e = exp_q_a.pop_front(); k = rd_a % 32; rd_a++;
      total++; if (rx_dat_log_a[k] !== e.d) begin bad++; $display("FAIL rstmid_next_data got=%h want=%h", rx_dat_log_a[k], e.d); end
      total++; if (rx_cyc_log_a[k] != e.c) begin bad++; $display("FAIL rstmid_next_latency got=%0d want=%0d", rx_cyc_log_a[k] - acc, LAT_A); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_const_miso();
    test_back_to_back();
    test_fast_div();
    test_busy_request();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
